htl_motion_ctrl: RTL and testbench

Per-frame motion controller for the player character. Samples the direction keys, start key and platform-contact flag once per video frame, then runs the fall/ride/death state machine. It drives the position and pose signals (`rel_xx`, `cnt_life`, `up_flg`, `face_RL`) consumed directly by the character sprite renderer. Sits between the key/collision logic and the sprite ROM stage, clocked by the 50 MHz system clock.

---
 rtl/htl_motion_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_htl_motion_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/htl_motion_ctrl.sv
// htl_motion_ctrl: per-frame motion controller for the player sprite.
// Samples keys and platform contact on frame_tick. Runs the IDLE/FALL/RIDE/DEAD state machine and
// drives the registered position/pose outputs read by the sprite renderer.
// Optional build macro: HTL_WRAP_X_EN makes the horizontal position wrap instead of saturating.
module htl_motion_ctrl #(
  parameter int unsigned STEP_X      = 3,
  parameter int unsigned X_LIM       = 375,
  parameter int unsigned START_Y     = 100,
  parameter int unsigned TOP_Y       = 20,
  parameter int unsigned BOTTOM_Y    = 550,
  parameter int unsigned RISE        = 1,
  parameter int unsigned FALL_MAX    = 8,
  parameter int unsigned DEAD_FRAMES = 60
) (
  input  logic               clk_50m,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               key_start,
  input  logic               on_platform,
  output logic signed [11:0] rel_xx,
  output logic        [9:0]  cnt_life,
  output logic               up_flg,
  output logic               face_RL,
  output logic               dead
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFall = 2'd1;
  localparam logic [1:0] StRide = 2'd2;
  localparam logic [1:0] StDead = 2'd3;

  localparam int unsigned DeadW = (DEAD_FRAMES > 1) ? $clog2(DEAD_FRAMES) : 1;

  localparam logic signed [12:0] XStep  = 13'(STEP_X);
  localparam logic signed [12:0] XLim   = 13'(X_LIM);
  localparam logic signed [12:0] XLimN  = -13'(X_LIM);
`ifdef HTL_WRAP_X_EN
  localparam logic signed [12:0] XSpan  = 13'(2 * X_LIM + 1);
`endif
  localparam logic signed [11:0] TopY   = 12'(TOP_Y);
  localparam logic signed [11:0] RiseY  = 12'(RISE);
  localparam logic        [10:0] BotY   = 11'(BOTTOM_Y);
  localparam logic        [3:0]  VelMax = 4'(FALL_MAX);

  logic        [1:0]       state_q, state_d;
  logic signed [11:0]      rel_q, rel_d;
  logic        [9:0]       cnt_q, cnt_d;
  logic                    up_q, up_d;
  logic                    face_q, face_d;
  logic                    dead_q, dead_d;
  logic        [3:0]       vel_q, vel_d;
  logic        [DeadW-1:0] dcnt_q, dcnt_d;

  // Horizontal candidate for this tick: step, then saturate (or wrap) in 13 bits.
  logic signed [12:0] x_sum;
  logic signed [12:0] x_new;
  logic signed [11:0] rel_mv;
  logic               face_mv;

  // Horizontal step and limit handling
  always_comb begin
    x_sum   = {rel_q[11], rel_q};
    face_mv = face_q;
    if (key_left && !key_right) begin
      x_sum   = x_sum + XStep;
      face_mv = 1'b0;
    end else if (key_right && !key_left) begin
      x_sum   = x_sum - XStep;
      face_mv = 1'b1;
    end
    x_new = x_sum;
`ifdef HTL_WRAP_X_EN
    if (x_sum > XLim) begin
      x_new = x_sum - XSpan;
    end else if (x_sum < XLimN) begin
      x_new = x_sum + XSpan;
    end
`else
    if (x_sum > XLim) begin
      x_new = XLim;
    end else if (x_sum < XLimN) begin
      x_new = XLimN;
    end
`endif
    rel_mv = x_new[11:0];
  end

  // Vertical candidates: falling adds the current velocity, riding lifts by RISE.
  logic        [10:0] y_fall;
  logic signed [11:0] y_ride;
  logic        [3:0]  vel_inc;

  // Vertical arithmetic for FALL and RIDE
  always_comb begin
    y_fall  = {1'b0, cnt_q} + {7'b0, vel_q};
    y_ride  = $signed({2'b00, cnt_q}) - RiseY;
    vel_inc = (vel_q >= VelMax) ? VelMax : vel_q + 4'd1;
  end

  // Next-state logic; everything holds unless frame_tick is high
  always_comb begin
    state_d = state_q;
    rel_d   = rel_q;
    cnt_d   = cnt_q;
    face_d  = face_q;
    vel_d   = vel_q;
    dcnt_d  = dcnt_q;

    if (frame_tick) begin
      case (state_q)
        StIdle: begin
          if (key_start) begin
            state_d = StFall;
            vel_d   = 4'd0;
          end
        end

        StFall: begin
          rel_d  = rel_mv;
          face_d = face_mv;
          if (on_platform) begin
            state_d = StRide;
            vel_d   = 4'd0;
          end else begin
            vel_d = vel_inc;
            if (y_fall >= BotY) begin
              cnt_d   = 10'(BOTTOM_Y);
              state_d = StDead;
              dcnt_d  = '0;
            end else begin
              cnt_d = y_fall[9:0];
            end
          end
        end

        StRide: begin
          rel_d  = rel_mv;
          face_d = face_mv;
          if (!on_platform) begin
            state_d = StFall;
            vel_d   = 4'd1;
          end else if (y_ride <= TopY) begin
            cnt_d   = 10'(TOP_Y);
            state_d = StDead;
            dcnt_d  = '0;
          end else begin
            cnt_d = y_ride[9:0];
          end
        end

        StDead: begin
          // Keys and platform are ignored; only the respawn counter advances.
          if (dcnt_q == DeadW'(DEAD_FRAMES - 1)) begin
            state_d = StIdle;
            rel_d   = '0;
            cnt_d   = 10'(START_Y);
            vel_d   = 4'd0;
            dcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + DeadW'(1);
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end

    up_d   = (state_d == StRide);
    dead_d = (state_d == StDead) && (state_q != StDead);
  end

  // State and output registers, asynchronous active-low reset
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rel_q   <= '0;
      cnt_q   <= 10'(START_Y);
      up_q    <= 1'b0;
      face_q  <= 1'b0;
      dead_q  <= 1'b0;
      vel_q   <= 4'd0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      face_q  <= face_d;
      dead_q  <= dead_d;
      vel_q   <= vel_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign rel_xx   = rel_q;
  assign cnt_life = cnt_q;
  assign up_flg   = up_q;
  assign face_RL  = face_q;
  assign dead     = dead_q;

endmodule

// File: tb/tb_htl_motion_ctrl.sv
// Directed bench for htl_motion_ctrl: reset, falling, riding, horizontal limits, both deaths,
// respawn and asynchronous reset mid-ride.
module tb_htl_motion_ctrl;

  logic               clk_50m = 1'b0;
  logic               rst_n = 1'b0;
  logic               frame_tick = 1'b0;
  logic               key_left = 1'b0;
  logic               key_right = 1'b0;
  logic               key_start = 1'b0;
  logic               on_platform = 1'b0;
  logic signed [11:0] rel_xx;
  logic        [9:0]  cnt_life;
  logic               up_flg;
  logic               face_RL;
  logic               dead;

  int errors = 0;
  int checks = 0;

  htl_motion_ctrl dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_start  (key_start),
    .on_platform(on_platform),
    .rel_xx     (rel_xx),
    .cnt_life   (cnt_life),
    .up_flg     (up_flg),
    .face_RL    (face_RL),
    .dead       (dead)
  );

  always #10 clk_50m = ~clk_50m;

  initial begin
    #2ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // One frame tick with the given inputs; returns on the next negedge with outputs updated.
  task automatic tick(input logic l, input logic r, input logic s, input logic p);
    key_left    = l;
    key_right   = r;
    key_start   = s;
    on_platform = p;
    frame_tick  = 1'b1;
    @(negedge clk_50m);
    frame_tick  = 1'b0;
    key_left    = 1'b0;
    key_right   = 1'b0;
    key_start   = 1'b0;
    on_platform = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_50m);
    checks++; if (rel_xx !== 12'sd0) begin errors++; $display("FAIL reset_rel got %0d want 0", rel_xx); end
    checks++; if (cnt_life !== 10'd100) begin errors++; $display("FAIL reset_cnt got %0d want 100", cnt_life); end
    checks++; if (up_flg !== 1'b0) begin errors++; $display("FAIL reset_up got %b want 0", up_flg); end
    checks++; if (face_RL !== 1'b0) begin errors++; $display("FAIL reset_face got %b want 0", face_RL); end
    checks++; if (dead !== 1'b0) begin errors++; $display("FAIL reset_dead got %b want 0", dead); end
    rst_n = 1'b1;
    @(negedge clk_50m);
    // Start held without a tick must do nothing.
    key_start = 1'b1;
    repeat (3) @(negedge clk_50m);
    key_start = 1'b0;
    // Idle tick without start: position frozen even with a key held.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (rel_xx !== 12'sd0) begin errors++; $display("FAIL idle_rel got %0d want 0", rel_xx); end
    checks++; if (cnt_life !== 10'd100) begin errors++; $display("FAIL idle_cnt got %0d want 100", cnt_life); end
  endtask

  task automatic test_fall();
    int exp_y[10] = '{100, 101, 103, 106, 110, 115, 121, 128, 136, 144};
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (cnt_life !== 10'd100) begin errors++; $display("FAIL start_cnt got %0d want 100", cnt_life); end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (cnt_life !== 10'(exp_y[i])) begin
        errors++; $display("FAIL fall_cnt[%0d] got %0d want %0d", i, cnt_life, exp_y[i]);
      end
    end
    repeat (3) @(negedge clk_50m);
    checks++; if (cnt_life !== 10'd144) begin errors++; $display("FAIL hold_cnt got %0d want 144", cnt_life); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (up_flg !== 1'b1) begin errors++; $display("FAIL land_up got %b want 1", up_flg); end
    checks++; if (cnt_life !== 10'd144) begin errors++; $display("FAIL land_cnt got %0d want 144", cnt_life); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (cnt_life !== 10'd143) begin errors++; $display("FAIL ride_cnt got %0d want 143", cnt_life); end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (up_flg !== 1'b0) begin errors++; $display("FAIL leave_up got %b want 0", up_flg); end
    checks++; if (cnt_life !== 10'd143) begin errors++; $display("FAIL leave_cnt got %0d want 143", cnt_life); end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (cnt_life !== 10'd144) begin errors++; $display("FAIL refall1_cnt got %0d want 144", cnt_life); end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (cnt_life !== 10'd146) begin errors++; $display("FAIL refall2_cnt got %0d want 146", cnt_life); end
  endtask

  // Alternating land/leave keeps cnt_life fixed while moving horizontally every tick.
  task automatic test_horizontal();
    for (int i = 0; i < 200; i++) begin
      tick(1'b0, 1'b1, 1'b0, (i % 2) == 0);
      if (i == 0) begin
        checks++; if (rel_xx !== -12'sd3) begin errors++; $display("FAIL right1_rel got %0d want -3", rel_xx); end
        checks++; if (face_RL !== 1'b1) begin errors++; $display("FAIL right1_face got %b want 1", face_RL); end
      end
    end
    checks++; if (rel_xx !== -12'sd375) begin errors++; $display("FAIL sat_rel got %0d want -375", rel_xx); end
    checks++; if (cnt_life !== 10'd146) begin errors++; $display("FAIL sat_cnt got %0d want 146", cnt_life); end
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    checks++; if (rel_xx !== -12'sd375) begin errors++; $display("FAIL both_rel got %0d want -375", rel_xx); end
    checks++; if (face_RL !== 1'b1) begin errors++; $display("FAIL both_face got %b want 1", face_RL); end
    checks++; if (up_flg !== 1'b1) begin errors++; $display("FAIL both_up got %b want 1", up_flg); end
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (rel_xx !== -12'sd372) begin errors++; $display("FAIL left_rel got %0d want -372", rel_xx); end
    checks++; if (face_RL !== 1'b0) begin errors++; $display("FAIL left_face got %b want 0", face_RL); end
    checks++; if (cnt_life !== 10'd145) begin errors++; $display("FAIL left_cnt got %0d want 145", cnt_life); end
  endtask

  task automatic test_ride_death();
    repeat (124) tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (cnt_life !== 10'd21) begin errors++; $display("FAIL pre_top_cnt got %0d want 21", cnt_life); end
    checks++; if (dead !== 1'b0) begin errors++; $display("FAIL pre_top_dead got %b want 0", dead); end
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    checks++; if (cnt_life !== 10'd20) begin errors++; $display("FAIL top_cnt got %0d want 20", cnt_life); end
    checks++; if (dead !== 1'b1) begin errors++; $display("FAIL top_dead got %b want 1", dead); end
    checks++; if (up_flg !== 1'b0) begin errors++; $display("FAIL top_up got %b want 0", up_flg); end
    checks++; if (rel_xx !== -12'sd375) begin errors++; $display("FAIL top_rel got %0d want -375", rel_xx); end
    checks++; if (face_RL !== 1'b1) begin errors++; $display("FAIL top_face got %b want 1", face_RL); end
    @(negedge clk_50m);
    checks++; if (dead !== 1'b0) begin errors++; $display("FAIL top_pulse got %b want 0", dead); end
    repeat (59) tick(1'b1, 1'b0, 1'b1, 1'b1);
    checks++; if (cnt_life !== 10'd20) begin errors++; $display("FAIL dead_cnt got %0d want 20", cnt_life); end
    checks++; if (rel_xx !== -12'sd375) begin errors++; $display("FAIL dead_rel got %0d want -375", rel_xx); end
    checks++; if (up_flg !== 1'b0) begin errors++; $display("FAIL dead_up got %b want 0", up_flg); end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (cnt_life !== 10'd100) begin errors++; $display("FAIL respawn_cnt got %0d want 100", cnt_life); end
    checks++; if (rel_xx !== 12'sd0) begin errors++; $display("FAIL respawn_rel got %0d want 0", rel_xx); end
    checks++; if (face_RL !== 1'b1) begin errors++; $display("FAIL respawn_face got %b want 1", face_RL); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (up_flg !== 1'b0) begin errors++; $display("FAIL respawn_idle_up got %b want 0", up_flg); end
    checks++; if (cnt_life !== 10'd100) begin errors++; $display("FAIL respawn_idle_cnt got %0d want 100", cnt_life); end
  endtask

  task automatic test_floor_death();
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (8) tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (cnt_life !== 10'd128) begin errors++; $display("FAIL floor_v8_cnt got %0d want 128", cnt_life); end
    repeat (52) tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (cnt_life !== 10'd544) begin errors++; $display("FAIL pre_floor_cnt got %0d want 544", cnt_life); end
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (cnt_life !== 10'd550) begin errors++; $display("FAIL floor_cnt got %0d want 550", cnt_life); end
    checks++; if (dead !== 1'b1) begin errors++; $display("FAIL floor_dead got %b want 1", dead); end
    checks++; if (rel_xx !== 12'sd3) begin errors++; $display("FAIL floor_rel got %0d want 3", rel_xx); end
    checks++; if (face_RL !== 1'b0) begin errors++; $display("FAIL floor_face got %b want 0", face_RL); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (up_flg !== 1'b0) begin errors++; $display("FAIL floor_plat_up got %b want 0", up_flg); end
    checks++; if (cnt_life !== 10'd550) begin errors++; $display("FAIL floor_plat_cnt got %0d want 550", cnt_life); end
    checks++; if (dead !== 1'b0) begin errors++; $display("FAIL floor_pulse got %b want 0", dead); end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    @(negedge clk_50m);
    rst_n = 1'b1;
    @(negedge clk_50m);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 125; i++) tick(1'b1, 1'b0, 1'b0, (i % 2) == 0);
    checks++; if (rel_xx !== 12'sd375) begin errors++; $display("FAIL left_edge_rel got %0d want 375", rel_xx); end
    tick(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef HTL_WRAP_X_EN
    checks++; if (rel_xx !== -12'sd373) begin errors++; $display("FAIL wrap_rel got %0d want -373", rel_xx); end
`else
    checks++; if (rel_xx !== 12'sd375) begin errors++; $display("FAIL clamp_rel got %0d want 375", rel_xx); end
`endif
    checks++; if (cnt_life !== 10'd100) begin errors++; $display("FAIL wrap_cnt got %0d want 100", cnt_life); end
  endtask

  task automatic test_reset_mid_ride();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    checks++; if (cnt_life !== 10'd99) begin errors++; $display("FAIL mid_ride_cnt got %0d want 99", cnt_life); end
    checks++; if (up_flg !== 1'b1) begin errors++; $display("FAIL mid_ride_up got %b want 1", up_flg); end
    #5;
    rst_n = 1'b0;
    #1;
    checks++; if (rel_xx !== 12'sd0) begin errors++; $display("FAIL arst_rel got %0d want 0", rel_xx); end
    checks++; if (cnt_life !== 10'd100) begin errors++; $display("FAIL arst_cnt got %0d want 100", cnt_life); end
    checks++; if (up_flg !== 1'b0) begin errors++; $display("FAIL arst_up got %b want 0", up_flg); end
    checks++; if (face_RL !== 1'b0) begin errors++; $display("FAIL arst_face got %b want 0", face_RL); end
    checks++; if (dead !== 1'b0) begin errors++; $display("FAIL arst_dead got %b want 0", dead); end
    @(negedge clk_50m);
    rst_n = 1'b1;
    @(negedge clk_50m);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (up_flg !== 1'b0) begin errors++; $display("FAIL post_rst_up got %b want 0", up_flg); end
    checks++; if (rel_xx !== 12'sd0) begin errors++; $display("FAIL post_rst_rel got %0d want 0", rel_xx); end
  endtask

  initial begin
    test_reset();
    test_fall();
    test_horizontal();
    test_ride_death();
    test_floor_death();
    test_wrap();
    test_reset_mid_ride();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
